ram_port_arbiter: RTL
=====================

Name: ram_port_arbiter

Overview:
Shares the single read/write port (port A) of the 64x16 dual-port synchronous-read RAM between two client masters. Each client has a req/gnt handshake and per-access read-data return. Round-robin arbitration applies, with optional burst lock bounded by MAX_BURST. Port B (read-only, DPRA/DPO) is not routed through this block.

Parameters:
ADDR_W, 6, RAM address width (64 words)
DATA_W, 16, RAM data width
MAX_BURST, 4, max consecutive locked grants to one client while the other is requesting (>=1)

Ports:
CLK  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req0, req1  in  1  client access request
lock0, lock1  in  1  client requests to keep ownership after this access
we0, we1  in  1  1=write, 0=read, qualified by req
addr0, addr1  in  ADDR_W  client word address
wdata0, wdata1  in  DATA_W  client write data
gnt0, gnt1  out  1  access accepted this cycle (combinational, Mealy)
rvalid0, rvalid1  out  1  read data valid on rdata (registered)
rdata  out  DATA_W  read return, equals ram_spo
ram_we  out  1  to RAM we
ram_addr  out  ADDR_W  to RAM address
ram_di  out  DATA_W  to RAM DI
ram_spo  in  DATA_W  from RAM SPO

Behaviour:
- Reset (async, rst_n=0): state=IDLE, last=1 (client 0 wins first tie), burst_cnt=0, rvalid0/1=0. gnt0/1 forced 0 while rst_n=0.
- States: IDLE (no owner), OWN0, OWN1. Exactly one of gnt0/gnt1 is high in any cycle, or neither.
- Grant rule each cycle:
  - state OWNk, req_k=1, and (other client idle or burst_cnt < MAX_BURST-1) -> gnt_k.
  - Else round-robin among requesters: if both request, grant the client != last; if one requests, grant it; if none, no grant.
- Transaction: in a granted cycle, ram_addr/ram_di/ram_we come from the granted client; ram_we = we_k & gnt_k. With no grant: ram_we=0, ram_addr/ram_di hold the client-0 values (don't care, no write).
- Accesses complete at the rising edge of the granted cycle; one access per client per gnt cycle. A client keeps addr/we/wdata stable while req=1 && gnt=0.
- Next state after a granted cycle of client k: OWNk if lock_k=1, else IDLE. last<=k.
  - burst_cnt<=burst_cnt+1 if the grant continued an ownership; otherwise 0.
  - burst_cnt saturates at MAX_BURST-1.
- No grant: state<=IDLE, burst_cnt<=0, last unchanged.
- Owner drops req while in OWNk: ownership ends, and normal round-robin applies that cycle.
- Read latency: rvalid_k <= gnt_k & ~we_k, so it rises 1 cycle after the grant. rdata = ram_spo, valid only while rvalid_k is high.
- Back-to-back reads give one rvalid per cycle.
- Read of an address written in the same cycle: the RAM returns the new data (write-first), and the arbiter passes it through.
- Simultaneous write by one client and read by the other is impossible (single grant).
- Reset mid-operation: the pending rvalid is dropped, ownership is lost, and no partial write occurs beyond the edge already taken.

Decomposition:
- Package ram_arb_pkg holds ADDR_W/DATA_W defaults and the state encoding (IDLE=2'd0, OWN0=2'd1, OWN1=2'd2).
- One natural sub-module: rr_pick2, a combinational 2-way round-robin picker (req[1:0], last -> onehot gnt).
- The FSM, burst counter, muxing and rvalid registers live in ram_port_arbiter.

Test Plan:
- Reset, then req0=1 we0=1 addr0=5 wdata0=16'hABCD -> gnt0 same cycle. Next cycle req0 read addr0=5 -> gnt0, and rvalid0=1 the following cycle with rdata=16'hABCD.
- req0=req1=1 both unlocked reads for 6 cycles -> grants alternate 0,1,0,1,0,1. rvalid follows each grant by 1 cycle.
- req0 lock0=1 continuous, req1=1, MAX_BURST=4 -> gnt0 for 4 consecutive cycles, then gnt1 for 1 cycle, then gnt0 again.
- Only req1 with lock1=1 for 10 cycles -> gnt1 every cycle (no cap without contention). burst_cnt saturates at 3.
- Client 0 writes addr 9=16'h1234 while client 1 reads addr 9 next cycle -> rdata=16'h1234 on rvalid1. Port B read of addr 9 is unaffected by the arbiter.
- Assert rst_n=0 in the cycle after a read grant -> rvalid cleared immediately, gnt0/1=0 during reset, state IDLE. After release, client 0 wins a tie.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared defaults and state encoding for the RAM port-A arbiter.
package ram_arb_pkg;

  localparam int unsigned RamAddrW = 6;
  localparam int unsigned RamDataW = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOwn0 = 2'd1,
    StOwn1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker: on a tie the client that did not win last goes first.
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares RAM port A between two req/gnt clients with round-robin arbitration and bounded lock.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = RamAddrW,
  parameter int unsigned DATA_W    = RamDataW,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_di,
  input  logic [DATA_W-1:0] ram_spo
);

  localparam int unsigned BurstW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BurstW-1:0] BurstMax = BurstW'(MAX_BURST - 1);

  arb_state_e        state_q, state_d;
  logic              last_q, last_d;
  logic [BurstW-1:0] cnt_q, cnt_d;
  logic              rvalid0_q, rvalid1_q;

  logic [1:0] rr_gnt;
  logic [1:0] gnt;
  logic       keep0, keep1;

  function automatic logic [BurstW-1:0] sat_inc(input logic [BurstW-1:0] v);
    return (v == BurstMax) ? v : v + 1'b1;
  endfunction

  rr_pick2 u_pick (
    .req_i  ({req1, req0}),
    .last_i (last_q),
    .gnt_o  (rr_gnt)
  );

  // The owner keeps the port unless the other client has waited through a full burst.
  always_comb begin
    keep0 = (state_q == StOwn0) && req0 && (!req1 || (cnt_q < BurstMax));
    keep1 = (state_q == StOwn1) && req1 && (!req0 || (cnt_q < BurstMax));
    if (keep0) begin
      gnt = 2'b01;
    end else if (keep1) begin
      gnt = 2'b10;
    end else begin
      gnt = rr_gnt;
    end
    if (!rst_n) begin
      gnt = 2'b00;
    end
  end

  assign gnt0 = gnt[0];
  assign gnt1 = gnt[1];

  always_comb begin
    ram_we   = (gnt[0] & we0) | (gnt[1] & we1);
    ram_addr = gnt[1] ? addr1 : addr0;
    ram_di   = gnt[1] ? wdata1 : wdata0;
  end

  always_comb begin
    state_d = StIdle;
    cnt_d   = '0;
    last_d  = last_q;
    if (gnt[0]) begin
      state_d = lock0 ? StOwn0 : StIdle;
      last_d  = 1'b0;
      if (state_q == StOwn0) begin
        cnt_d = sat_inc(cnt_q);
      end
    end else if (gnt[1]) begin
      state_d = lock1 ? StOwn1 : StIdle;
      last_d  = 1'b1;
      if (state_q == StOwn1) begin
        cnt_d = sat_inc(cnt_q);
      end
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      rvalid0_q <= gnt[0] & ~we0;
      rvalid1_q <= gnt[1] & ~we1;
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata   = ram_spo;

endmodule
